dmem_arbiter: RTL and testbench

//  Shares the single-port data RAM (12-bit word address, 32-bit data) between two requesters.

---
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : Two-requester request/grant/read-return bundle for dmem_arbiter
//  Revision : 1.0
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Fixed-priority sharer of a single-port data RAM, with a
//             starvation guard for port 1 and tagged one-cycle read return
//  Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  wire logic              clock,
    input  wire logic              reset,
    dmem_arbiter_if.slave          bus,
    output logic                   mem_wren,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    input  wire logic [DATA_W-1:0] mem_q
);

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD0  = 2'd1,
        S_RD1  = 2'd2
    } rd_state_t;

    rd_state_t         r_rd_pend;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [3:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_last_addr;

    logic w_force1;
    logic w_gnt0;
    logic w_gnt1;

    // Grants are suppressed while reset is low so no access can start then.
    assign w_force1 = bus.req1 && (r_wait_cnt == c_MAX_WAIT);
    assign w_gnt1   = reset && bus.req1 && (w_force1 || !bus.req0);
    assign w_gnt0   = reset && bus.req0 && !w_gnt1;

    assign bus.gnt0 = w_gnt0;
    assign bus.gnt1 = w_gnt1;

    always_comb begin
        mem_wren = 1'b0;
        mem_addr = r_last_addr;
        mem_data = '0;
        if (w_gnt1) begin
            mem_wren = bus.we1;
            mem_addr = bus.addr1;
            mem_data = bus.wdata1;
        end else if (w_gnt0) begin
            mem_wren = bus.we0;
            mem_addr = bus.addr0;
            mem_data = bus.wdata0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_pend   <= S_IDLE;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_wait_cnt  <= 4'd0;
            r_last_addr <= '0;
        end else begin
            if (w_gnt1 || !bus.req1) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt < c_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            if (w_gnt0 || w_gnt1) begin
                r_last_addr <= mem_addr;
            end

            if (w_gnt0 && !bus.we0) begin
                r_rd_pend <= S_RD0;
                r_rvalid0 <= 1'b1;
                r_rvalid1 <= 1'b0;
            end else if (w_gnt1 && !bus.we1) begin
                r_rd_pend <= S_RD1;
                r_rvalid0 <= 1'b0;
                r_rvalid1 <= 1'b1;
            end else begin
                r_rd_pend <= S_IDLE;
                r_rvalid0 <= 1'b0;
                r_rvalid1 <= 1'b0;
            end
        end
    end

    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata0  = r_rvalid0 ? mem_q : '0;
    assign bus.rdata1  = r_rvalid1 ? mem_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed bench for dmem_arbiter with a behavioural sync-read RAM
//  Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clock;
    logic              reset;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_q;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int n_checks;
    int n_errors;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave),
        .mem_wren (mem_wren),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_q    (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM: one cycle read latency, write lands at the edge.
    always @(posedge clock) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mem_q    = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        idle_bus();

        // Reset held two cycles with both ports requesting writes.
        reset    = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.we0  = 1'b1;
        bus.we1  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst_gnt0", 32'(bus.gnt0), 32'd0);
            check("rst_gnt1", 32'(bus.gnt1), 32'd0);
            check("rst_wren", 32'(mem_wren), 32'd0);
            tick();
            check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
            check("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
        end
        idle_bus();
        reset = 1'b1;
        tick();

        // Port 0 alone: write then read back.
        bus.req0   = 1'b1;
        bus.we0    = 1'b1;
        bus.addr0  = 12'h010;
        bus.wdata0 = 32'hDEADBEEF;
        #1;
        check("p0w_gnt0", 32'(bus.gnt0), 32'd1);
        check("p0w_gnt1", 32'(bus.gnt1), 32'd0);
        check("p0w_wren", 32'(mem_wren), 32'd1);
        check("p0w_addr", 32'(mem_addr), 32'h010);
        check("p0w_data", mem_data, 32'hDEADBEEF);
        tick();
        bus.we0 = 1'b0;
        #1;
        check("p0r_gnt0", 32'(bus.gnt0), 32'd1);
        check("p0r_wren", 32'(mem_wren), 32'd0);
        tick();
        bus.req0 = 1'b0;
        #1;
        check("p0r_rvalid0", 32'(bus.rvalid0), 32'd1);
        check("p0r_rdata0", bus.rdata0, 32'hDEADBEEF);
        check("p0r_rvalid1", 32'(bus.rvalid1), 32'd0);
        check("idle_addr_hold", 32'(mem_addr), 32'h010);
        check("idle_data_zero", mem_data, 32'd0);
        tick();
        check("p0r_rvalid0_drop", 32'(bus.rvalid0), 32'd0);
        check("p0r_rdata0_zero", bus.rdata0, 32'd0);

        // Contention: both read for 10 cycles; port 1 forced on cycles 5 and 10.
        bus.req0  = 1'b1;
        bus.we0   = 1'b0;
        bus.addr0 = 12'h020;
        bus.req1  = 1'b1;
        bus.we1   = 1'b0;
        bus.addr1 = 12'h030;
        for (int k = 1; k <= 10; k++) begin
            logic exp_g1;
            logic [3:0] exp_wc;
            exp_g1 = (k == 5) || (k == 10);
            exp_wc = 4'((k - 1) % 5);
            #1;
            check($sformatf("cont_wait_%0d", k), 32'(dut.r_wait_cnt), 32'(exp_wc));
            check($sformatf("cont_gnt1_%0d", k), 32'(bus.gnt1), 32'(exp_g1));
            check($sformatf("cont_gnt0_%0d", k), 32'(bus.gnt0), 32'(!exp_g1));
            tick();
            check($sformatf("cont_rvalid1_%0d", k), 32'(bus.rvalid1), 32'(exp_g1));
            check($sformatf("cont_rvalid0_%0d", k), 32'(bus.rvalid0), 32'(!exp_g1));
        end
        idle_bus();
        tick();

        // Port 1 writes the top address, port 0 reads it next cycle.
        bus.req1   = 1'b1;
        bus.we1    = 1'b1;
        bus.addr1  = 12'hFFF;
        bus.wdata1 = 32'h00001234;
        #1;
        check("il_gnt1", 32'(bus.gnt1), 32'd1);
        check("il_addr", 32'(mem_addr), 32'hFFF);
        tick();
        idle_bus();
        bus.req0  = 1'b1;
        bus.addr0 = 12'hFFF;
        #1;
        check("il_gnt0", 32'(bus.gnt0), 32'd1);
        tick();
        idle_bus();
        #1;
        check("il_rvalid0", 32'(bus.rvalid0), 32'd1);
        check("il_rdata0", bus.rdata0, 32'h00001234);
        check("il_rvalid1", 32'(bus.rvalid1), 32'd0);
        check("il_rdata1", bus.rdata1, 32'd0);
        tick();

        // Cancel: port 1 write denied twice, then withdrawn.
        bus.req0   = 1'b1;
        bus.addr0  = 12'h040;
        bus.req1   = 1'b1;
        bus.we1    = 1'b1;
        bus.addr1  = 12'h050;
        bus.wdata1 = 32'h00000BAD;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("cx_gnt1_%0d", k), 32'(bus.gnt1), 32'd0);
            check($sformatf("cx_wren_%0d", k), 32'(mem_wren), 32'd0);
            tick();
        end
        check("cx_wait_2", 32'(dut.r_wait_cnt), 32'd2);
        bus.req1 = 1'b0;
        #1;
        check("cx_gnt1_drop", 32'(bus.gnt1), 32'd0);
        tick();
        check("cx_wait_clr", 32'(dut.r_wait_cnt), 32'd0);
        check("cx_rvalid1", 32'(bus.rvalid1), 32'd0);
        bus.addr0 = 12'h050;
        tick();
        bus.req0 = 1'b0;
        #1;
        check("cx_rvalid0", 32'(bus.rvalid0), 32'd1);
        check("cx_no_write", bus.rdata0, 32'd0);
        tick();

        // Reset arrives in the cycle a port-1 read is granted.
        idle_bus();
        bus.req1  = 1'b1;
        bus.addr1 = 12'hFFF;
        #1;
        check("rr_gnt1_pre", 32'(bus.gnt1), 32'd1);
        reset = 1'b0;
        #1;
        check("rr_gnt1_rst", 32'(bus.gnt1), 32'd0);
        check("rr_wren_rst", 32'(mem_wren), 32'd0);
        tick();
        check("rr_rvalid1_a", 32'(bus.rvalid1), 32'd0);
        tick();
        check("rr_rvalid1_b", 32'(bus.rvalid1), 32'd0);
        check("rr_wait_rst", 32'(dut.r_wait_cnt), 32'd0);
        idle_bus();
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
